// File: rtl/h80cpu_uart_rx_io.sv
// h80cpu UART receive responder: 8N1 deserialiser into a byte FIFO, drained by
// CPU reads over the run/done toggle handshake (CPU clk sampled on sysclk).
package h80cpu_bus_pkg;
  typedef enum logic [1:0] {
    bus_cmd_idle_b  = 2'd0,
    bus_cmd_read_b  = 2'd1,
    bus_cmd_write_b = 2'd2
  } bus_cmd_t;
endpackage

module h80cpu_uart_rx_io
  import h80cpu_bus_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter logic [ADDR_W-1:0] DATA_ADDR = 'h0001,
  parameter logic [ADDR_W-1:0] STAT_ADDR = 'h0002
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  bus_cmd_t          cmd,
  input  logic              run,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  input  logic              uart_rxp,
  output logic              rx_irq
);
  localparam int DIV  = CLK_FREQ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam int AW   = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT_HIGH} rx_st_t;
  typedef enum logic {B_IDLE, B_WAIT_DATA} bus_st_t;

  logic [1:0]        r_sync;
  logic              w_rx_s;
  rx_st_t            r_rx_st, w_rx_nx;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_bit;
  logic [7:0]        r_shreg;
  logic              w_tick_half, w_tick_bit, w_push, w_ferr;

  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [AW:0]       r_count, w_count_nx;
  logic              w_full, w_nempty, w_push_ok;
  logic              r_frame_err, r_overrun;

  bus_st_t           r_bus_st, w_bus_nx;
  logic              r_prev_clk, w_ev, w_pend;
  logic              w_pop, w_stat_rd;
  logic [DATA_W-1:0] w_stat;

  assign w_rx_s = r_sync[1];

  always_ff @(posedge sysclk) begin
    if (reset) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], uart_rxp};
  end

  // ---------------- RX deserialiser ----------------
  always_comb begin
    w_rx_nx     = r_rx_st;
    w_push      = 1'b0;
    w_ferr      = 1'b0;
    w_tick_half = (r_cnt == CW'(HALF - 1));
    w_tick_bit  = (r_cnt == CW'(DIV - 1));
    case (r_rx_st)
      R_IDLE:      if (!w_rx_s) w_rx_nx = R_START;
      R_START:     if (w_tick_half) w_rx_nx = w_rx_s ? R_IDLE : R_DATA;
      R_DATA:      if (w_tick_bit && r_bit == 3'd7) w_rx_nx = R_STOP;
      R_STOP: if (w_tick_bit) begin
        if (w_rx_s) begin w_push = 1'b1; w_rx_nx = R_IDLE; end
        else        begin w_ferr = 1'b1; w_rx_nx = R_WAIT_HIGH; end
      end
      R_WAIT_HIGH: if (w_rx_s) w_rx_nx = R_IDLE;
      default:     w_rx_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_rx_st <= R_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
    end else begin
      r_rx_st <= w_rx_nx;
      // counter restarts on every state change and at each bit boundary
      r_cnt   <= (w_rx_nx != r_rx_st || w_tick_bit) ? '0 : r_cnt + CW'(1);
      if (r_rx_st == R_START) r_bit <= '0;
      else if (r_rx_st == R_DATA && w_tick_bit) begin
        r_bit   <= r_bit + 3'd1;
        r_shreg <= {w_rx_s, r_shreg[7:1]};
      end
    end
  end

  // ---------------- FIFO ----------------
  assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_nempty   = (r_count != '0);
  assign w_push_ok  = w_push && !w_full;
  assign w_count_nx = r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop);

  always_ff @(posedge sysclk) begin
    if (w_push_ok) r_mem[r_wptr] <= r_shreg;
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      rx_irq      <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop)     r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_nx;
      rx_irq  <= (w_count_nx != '0);
      // a new error in the same cycle as a status read survives the clear
      if (w_ferr)              r_frame_err <= 1'b1;
      else if (w_stat_rd)      r_frame_err <= 1'b0;
      if (w_push && w_full)    r_overrun   <= 1'b1;
      else if (w_stat_rd)      r_overrun   <= 1'b0;
    end
  end

  // ---------------- bus responder ----------------
  assign w_ev   = !r_prev_clk && clk;
  assign w_pend = (run != done);

  always_comb begin
    w_stat        = '0;
    w_stat[0]     = w_nempty;
    w_stat[1]     = r_frame_err;
    w_stat[2]     = r_overrun;
    w_stat[15:8]  = 8'(r_count);
  end

  always_comb begin
    w_bus_nx  = r_bus_st;
    w_pop     = 1'b0;
    w_stat_rd = 1'b0;
    case (r_bus_st)
      B_IDLE: if (w_ev && w_pend && cmd == bus_cmd_read_b) begin
        if (addr == DATA_ADDR) begin
          if (w_nempty) w_pop = 1'b1;
          else          w_bus_nx = B_WAIT_DATA;
        end else if (addr == STAT_ADDR) w_stat_rd = 1'b1;
      end
      B_WAIT_DATA: if (w_ev && w_nempty) begin
        w_pop    = 1'b1;
        w_bus_nx = B_IDLE;
      end
      default: w_bus_nx = B_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_bus_st   <= B_IDLE;
      r_prev_clk <= 1'b0;
      rd_data    <= '0;
      done       <= 1'b0;
    end else begin
      r_bus_st   <= w_bus_nx;
      r_prev_clk <= clk;
      if (w_pop) begin
        rd_data <= DATA_W'(r_mem[r_rptr]);
        done    <= !done;
      end else if (w_stat_rd) begin
        rd_data <= w_stat;
        done    <= !done;
      end
    end
  end
endmodule
